// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU memory-mapped responder: RAM, TX FIFO, cycle counter, LED register
module mem_responder #(
    parameter int RAM_AW  = 12,
    parameter int FIFO_AW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_raddr_i,
    output logic [15:0] mem_rdata_o,
    input  logic [15:0] mem_waddr_i,
    input  logic [15:0] mem_wdata_i,
    input  logic        mem_wr_i,
    input  logic        mem_rd_i,
    output logic [15:0] tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i,
    output logic [15:0] led_o
);

    localparam logic [15:0] ADDR_STATUS = 16'hF000;
    localparam logic [15:0] ADDR_TXDATA = 16'hF001;
    localparam logic [15:0] ADDR_CYCLES = 16'hF002;
    localparam logic [15:0] ADDR_LED    = 16'hF003;

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW-1:0] PTR_ONE    = {{(FIFO_AW-1){1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW:0]   CNT_FULL   = {1'b1, {FIFO_AW{1'b0}}};

    logic [15:0]        ram      [0:(1<<RAM_AW)-1];
    logic [15:0]        fifo_mem [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow_q;
    logic [15:0]        cycles_q;
    logic [15:0]        led_q;

    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        ovf_set;
    logic        ovf_clr;
    logic        raddr_is_ram;
    logic        waddr_is_ram;
    logic        ram_we;
    logic        cycles_we;
    logic        led_we;
    logic [15:0] count_ext;
    logic [3:0]  cnt_field;
    logic [15:0] status_word;
    logic [15:0] rd_mux;

    assign empty     = (count == '0);
    assign full      = (count == CNT_FULL);
    assign tx_valid_o = ~empty;
    // Head is forced to zero when empty so reset shows 0 without clearing the storage
    assign tx_data_o = empty ? 16'h0000 : fifo_mem[rd_ptr];
    assign led_o     = led_q;

    assign pop       = tx_valid_o & tx_ready_i;
    assign push_req  = mem_wr_i & (mem_waddr_i == ADDR_TXDATA);
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign push      = push_req & (~full | pop);
    assign ovf_set   = push_req & ~push;
    assign ovf_clr   = mem_wr_i & (mem_waddr_i == ADDR_STATUS) & mem_wdata_i[2];
    assign cycles_we = mem_wr_i & (mem_waddr_i == ADDR_CYCLES);
    assign led_we    = mem_wr_i & (mem_waddr_i == ADDR_LED);

    assign raddr_is_ram = ((mem_raddr_i >> RAM_AW) == 16'h0000);
    assign waddr_is_ram = ((mem_waddr_i >> RAM_AW) == 16'h0000);
    assign ram_we       = mem_wr_i & waddr_is_ram;

    assign count_ext   = 16'(count);
    assign cnt_field   = (count_ext > 16'd15) ? 4'hF : count_ext[3:0];
    assign status_word = {8'h00, cnt_field, 1'b0, overflow_q, full, empty};

    // Read decode; registers are sampled before any same-edge write lands
    always_comb begin
        rd_mux = 16'h0000;
        if (raddr_is_ram) begin
            rd_mux = ram[mem_raddr_i[RAM_AW-1:0]];
        end else begin
            case (mem_raddr_i)
                ADDR_STATUS: rd_mux = status_word;
                ADDR_CYCLES: rd_mux = cycles_q;
                ADDR_LED:    rd_mux = led_q;
                default:     rd_mux = 16'h0000;
            endcase
        end
    end

    // Registered read data, held while mem_rd_i is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata_o <= 16'h0000;
        end else if (mem_rd_i) begin
            mem_rdata_o <= rd_mux;
        end
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[mem_waddr_i[RAM_AW-1:0]] <= mem_wdata_i;
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wdata_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a drop in the same cycle beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    // Free-running cycle counter, loadable by the CPU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_q <= 16'h0000;
        end else if (cycles_we) begin
            cycles_q <= mem_wdata_i;
        end else begin
            cycles_q <= cycles_q + 16'd1;
        end
    end

    // LED register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_q <= 16'h0000;
        end else if (led_we) begin
            led_q <= mem_wdata_i;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] mem_raddr_i;
    logic [15:0] mem_rdata_o;
    logic [15:0] mem_waddr_i;
    logic [15:0] mem_wdata_i;
    logic        mem_wr_i;
    logic        mem_rd_i;
    logic [15:0] tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i;
    logic [15:0] led_o;

    int errors;
    int checks;

    mem_responder #(.RAM_AW(12), .FIFO_AW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_raddr_i (mem_raddr_i),
        .mem_rdata_o (mem_rdata_o),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_wr_i    (mem_wr_i),
        .mem_rd_i    (mem_rd_i),
        .tx_data_o   (tx_data_o),
        .tx_valid_o  (tx_valid_o),
        .tx_ready_i  (tx_ready_i),
        .led_o       (led_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        mem_waddr_i = addr;
        mem_wdata_i = data;
        mem_wr_i    = 1'b1;
        tick();
        mem_wr_i    = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] addr);
        mem_raddr_i = addr;
        mem_rd_i    = 1'b1;
        tick();
        mem_rd_i    = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (mem_rdata_o !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h expected 0000", mem_rdata_o); end
        checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", tx_valid_o); end
        checks++; if (tx_data_o !== 16'h0000) begin errors++; $display("FAIL reset_txdata: got %h expected 0000", tx_data_o); end
        checks++; if (led_o !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h expected 0000", led_o); end
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0001) begin errors++; $display("FAIL reset_status: got %h expected 0001", mem_rdata_o); end
    endtask

    task automatic test_ram();
        do_write(16'h0005, 16'h1234);
        mem_raddr_i = 16'h0005; mem_rd_i = 1'b1;
        mem_waddr_i = 16'h0005; mem_wdata_i = 16'hBEEF; mem_wr_i = 1'b1;
        tick();
        mem_rd_i = 1'b0; mem_wr_i = 1'b0;
        checks++; if (mem_rdata_o !== 16'h1234) begin errors++; $display("FAIL ram_rw_same: got %h expected 1234", mem_rdata_o); end
        do_read(16'h0005);
        checks++; if (mem_rdata_o !== 16'hBEEF) begin errors++; $display("FAIL ram_reread: got %h expected BEEF", mem_rdata_o); end
        mem_raddr_i = 16'h0000;
        tick();
        checks++; if (mem_rdata_o !== 16'hBEEF) begin errors++; $display("FAIL rdata_hold: got %h expected BEEF", mem_rdata_o); end
        do_write(16'h0FFF, 16'h5A5A);
        do_read(16'h0FFF);
        checks++; if (mem_rdata_o !== 16'h5A5A) begin errors++; $display("FAIL ram_top: got %h expected 5A5A", mem_rdata_o); end
        do_read(16'h1000);
        checks++; if (mem_rdata_o !== 16'h0000) begin errors++; $display("FAIL ram_beyond: got %h expected 0000", mem_rdata_o); end
    endtask

    task automatic test_fifo_overflow();
        for (int i = 1; i <= 8; i++) do_write(16'hF001, 16'(i));
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0082) begin errors++; $display("FAIL status_full: got %h expected 0082", mem_rdata_o); end
        do_write(16'hF001, 16'h0009);
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0086) begin errors++; $display("FAIL status_ovf: got %h expected 0086", mem_rdata_o); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 16'(i)) begin
                errors++; $display("FAIL drain_%0d: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid_o, tx_data_o, 16'(i));
            end
            tx_ready_i = 1'b1; tick(); tx_ready_i = 1'b0;
        end
        checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", tx_valid_o); end
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0005) begin errors++; $display("FAIL status_drained: got %h expected 0005", mem_rdata_o); end
        do_write(16'hF000, 16'h0004);
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0001) begin errors++; $display("FAIL ovf_clear: got %h expected 0001", mem_rdata_o); end
    endtask

    task automatic test_full_push_pop();
        for (int i = 0; i < 8; i++) do_write(16'hF001, 16'h0010 + 16'(i));
        tick();
        checks++; if (tx_data_o !== 16'h0010) begin errors++; $display("FAIL head_stable: got %h expected 0010", tx_data_o); end
        tx_ready_i = 1'b1;
        do_write(16'hF001, 16'h00AA);
        tx_ready_i = 1'b0;
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0082) begin errors++; $display("FAIL full_pushpop_status: got %h expected 0082", mem_rdata_o); end
        for (int i = 1; i <= 8; i++) begin
            checks++; if (tx_data_o !== ((i == 8) ? 16'h00AA : 16'h0010 + 16'(i))) begin
                errors++; $display("FAIL full_drain_%0d: got %h expected %h", i, tx_data_o, (i == 8) ? 16'h00AA : 16'h0010 + 16'(i));
            end
            tx_ready_i = 1'b1; tick(); tx_ready_i = 1'b0;
        end
        checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL full_drain_empty: got %b expected 0", tx_valid_o); end
    endtask

    task automatic test_empty_push_pop();
        tx_ready_i = 1'b1;
        do_write(16'hF001, 16'h0077);
        checks++; if (tx_valid_o !== 1'b1 || tx_data_o !== 16'h0077) begin
            errors++; $display("FAIL empty_pushpop: got valid=%b data=%h expected valid=1 data=0077", tx_valid_o, tx_data_o);
        end
        tick();
        tx_ready_i = 1'b0;
        checks++; if (tx_valid_o !== 1'b0) begin errors++; $display("FAIL empty_pushpop_pop: got %b expected 0", tx_valid_o); end
    endtask

    task automatic test_cycles();
        do_write(16'hF002, 16'hFFFE);
        mem_raddr_i = 16'hF002; mem_rd_i = 1'b1;
        tick();
        checks++; if (mem_rdata_o !== 16'hFFFE) begin errors++; $display("FAIL cycles_0: got %h expected FFFE", mem_rdata_o); end
        tick();
        checks++; if (mem_rdata_o !== 16'hFFFF) begin errors++; $display("FAIL cycles_1: got %h expected FFFF", mem_rdata_o); end
        tick();
        checks++; if (mem_rdata_o !== 16'h0000) begin errors++; $display("FAIL cycles_wrap: got %h expected 0000", mem_rdata_o); end
        mem_rd_i = 1'b0;
    endtask

    task automatic test_unmapped();
        do_write(16'hF003, 16'h00A5);
        checks++; if (led_o !== 16'h00A5) begin errors++; $display("FAIL led_write: got %h expected 00A5", led_o); end
        do_read(16'h8000);
        checks++; if (mem_rdata_o !== 16'h0000) begin errors++; $display("FAIL unmapped_8000: got %h expected 0000", mem_rdata_o); end
        do_read(16'hF003);
        checks++; if (mem_rdata_o !== 16'h00A5) begin errors++; $display("FAIL led_read: got %h expected 00A5", mem_rdata_o); end
        do_read(16'hF004);
        checks++; if (mem_rdata_o !== 16'h0000) begin errors++; $display("FAIL unmapped_F004: got %h expected 0000", mem_rdata_o); end
        do_write(16'hF002, 16'h1000);
        do_write(16'hF004, 16'h5555);
        do_read(16'hF002);
        checks++; if (mem_rdata_o !== 16'h1001) begin errors++; $display("FAIL unmapped_cycles: got %h expected 1001", mem_rdata_o); end
        checks++; if (led_o !== 16'h00A5 || tx_valid_o !== 1'b0) begin
            errors++; $display("FAIL unmapped_side: got led=%h valid=%b expected led=00A5 valid=0", led_o, tx_valid_o);
        end
        do_write(16'hF001, 16'h0033);
        do_read(16'hF001);
        checks++; if (mem_rdata_o !== 16'h0000) begin errors++; $display("FAIL txdata_read: got %h expected 0000", mem_rdata_o); end
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0010) begin errors++; $display("FAIL txdata_nopop: got %h expected 0010", mem_rdata_o); end
    endtask

    task automatic test_async_reset();
        do_write(16'h0010, 16'hCAFE);
        do_write(16'hF001, 16'h0044);
        do_write(16'hF001, 16'h0055);
        do_write(16'hF003, 16'h00FF);
        do_read(16'h0010);
        checks++; if (mem_rdata_o !== 16'hCAFE || led_o !== 16'h00FF || tx_valid_o !== 1'b1) begin
            errors++; $display("FAIL pre_reset: got rdata=%h led=%h valid=%b expected CAFE 00FF 1", mem_rdata_o, led_o, tx_valid_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (mem_rdata_o !== 16'h0000 || led_o !== 16'h0000 || tx_valid_o !== 1'b0 || tx_data_o !== 16'h0000) begin
            errors++; $display("FAIL async_reset: got rdata=%h led=%h valid=%b txdata=%h expected all 0", mem_rdata_o, led_o, tx_valid_o, tx_data_o);
        end
        #1 rst_n = 1'b1;
        tick();
        do_read(16'h0010);
        checks++; if (mem_rdata_o !== 16'hCAFE) begin errors++; $display("FAIL ram_kept: got %h expected CAFE", mem_rdata_o); end
        do_read(16'hF000);
        checks++; if (mem_rdata_o !== 16'h0001) begin errors++; $display("FAIL status_after_reset: got %h expected 0001", mem_rdata_o); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        mem_raddr_i = 16'h0000;
        mem_waddr_i = 16'h0000;
        mem_wdata_i = 16'h0000;
        mem_wr_i = 1'b0;
        mem_rd_i = 1'b0;
        tx_ready_i = 1'b0;
        #23 rst_n = 1'b1;
        tick();
        test_reset();
        test_ram();
        test_fifo_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_cycles();
        test_unmapped();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
